// File: rtl/picorv32_mem_bridge_if.sv
// picorv32_mem_bridge_if: picorv32 native memory bus (core is master, bridge is slave)
interface picorv32_mem_bridge_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  modport master (output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, input mem_ready, mem_rdata);
  modport slave (input mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, output mem_ready, mem_rdata);
endinterface

// File: rtl/picorv32_mem_bridge.sv
// picorv32_mem_bridge: decodes picorv32 requests to block RAM, console, exit register or unmapped space
module picorv32_mem_bridge #(
  parameter int          RAM_WORDS    = 32768,
  parameter int          RAM_AW       = 15,
  parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
  parameter logic [31:0] EXIT_ADDR    = 32'h2000_0000,
  parameter bit          STALL_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  picorv32_mem_bridge_if.slave  bus,
  output logic                  ram_en,
  output logic [3:0]            ram_we,
  output logic [RAM_AW-1:0]     ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  output logic                  con_valid,
  output logic [7:0]            con_data,
  input  logic                  con_ready,
  output logic                  exit_req,
  output logic                  bus_err
);
  typedef enum logic [2:0] {IDLE, STALL, RAM_RD, CON, RESP} state_t;
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;
  state_t state, state_nx;
  logic [5:0] stall_cnt;
  logic [31:0] addr_q, wdata_q, rdata_q, addr_c, wdata_c;
  logic [3:0] wstrb_q, wstrb_c;
  logic stall, go, wr, ram_hit, con_hit, exit_hit, unused_ok;
  assign stall = STALL_EN && (stall_cnt < 6'd7 || stall_cnt % 6'd7 == 6'd0 || stall_cnt % 6'd5 == 6'd0);
  // In IDLE the request is dispatched straight from the bus; later states use the latched copy
  assign addr_c  = state == IDLE ? bus.mem_addr  : addr_q;
  assign wdata_c = state == IDLE ? bus.mem_wdata : wdata_q;
  assign wstrb_c = state == IDLE ? bus.mem_wstrb : wstrb_q;
  assign go = resetn && (state == IDLE ? bus.mem_valid && !stall : state == STALL && !stall);
  assign wr       = |wstrb_c;
  assign ram_hit  = {1'b0, addr_c} < RAM_BYTES;
  assign con_hit  = !ram_hit && addr_c == CONSOLE_ADDR;
  assign exit_hit = !ram_hit && !con_hit && addr_c == EXIT_ADDR;
  assign ram_en    = go && ram_hit;
  assign ram_we    = ram_en ? wstrb_c : 4'd0;
  assign ram_addr  = ram_en ? addr_c[RAM_AW+1:2] : '0;
  assign ram_wdata = ram_en ? wdata_c : 32'd0;
  assign con_valid = state == CON;
  assign con_data  = con_valid ? wdata_q[7:0] : 8'd0;
  assign bus.mem_ready = state == RESP;
  assign bus.mem_rdata = bus.mem_ready ? rdata_q : 32'd0;
  assign unused_ok = &{1'b0, bus.mem_instr};
  always_comb begin
    state_nx = state;
    if (go) state_nx = ram_hit && !wr ? RAM_RD : con_hit && wr ? CON : RESP;
    else if (state == IDLE && bus.mem_valid) state_nx = STALL;
    else if (state == RAM_RD || (state == CON && con_ready)) state_nx = RESP;
    else if (state == RESP) state_nx = IDLE;
  end
  always_ff @(posedge clk) state <= !resetn ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cnt <= 6'd0;
      addr_q <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      rdata_q <= 32'd0;
      exit_req <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt + 6'd1;
      rdata_q <= state == RAM_RD ? ram_rdata : 32'd0;
      if (state == IDLE) begin
        addr_q <= bus.mem_addr;
        wdata_q <= bus.mem_wdata;
        wstrb_q <= bus.mem_wstrb;
      end
      if (go && exit_hit && wr) exit_req <= 1'b1;
      if (go && !ram_hit && !con_hit && !exit_hit) bus_err <= 1'b1;
    end
  end
endmodule
